// File: rtl/decode_in_buffer_pkg.sv
// Shared types and constants for the decode input buffer: LC3 opcode
// values, the opclass encoding seen by decode, and the classifier.
package decode_in_buffer_pkg;

  typedef enum logic [1:0] {
    OPC_ALU   = 2'd0,
    OPC_MEM   = 2'd1,
    OPC_CTRL  = 2'd2,
    OPC_OTHER = 2'd3
  } opclass_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // JSR, RTI, TRAP and the reserved opcode deliberately fall into OTHER.
  function automatic opclass_e classify_opcode(input logic [3:0] op);
    opclass_e cls;
    case (op)
      OP_ADD, OP_AND, OP_NOT:                 cls = OPC_ALU;
      OP_LD, OP_LDR, OP_LDI, OP_LEA,
      OP_ST, OP_STR, OP_STI:                  cls = OPC_MEM;
      OP_BR, OP_JMP:                          cls = OPC_CTRL;
      default:                                cls = OPC_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/decode_in_buffer_if.sv
// Fetch-to-decode buffer bus. The master side is the fetch/decode
// environment; the slave side is the buffer itself.
interface decode_in_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int PSR_W  = 3
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              enable_decode;
  logic [DATA_W-1:0] instr_dout;
  logic [DATA_W-1:0] npc_in;
  logic [PSR_W-1:0]  psr;
  logic              flush;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_npc;
  logic [PSR_W-1:0]  out_psr;
  logic [1:0]        out_opclass;
  logic [CNT_W-1:0]  count;
  logic              overflow_err;

  modport master (
    output enable_decode, instr_dout, npc_in, psr, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_npc, out_psr,
           out_opclass, count, overflow_err
  );

  modport slave (
    input  enable_decode, instr_dout, npc_in, psr, flush, out_ready,
    output in_ready, out_valid, out_instr, out_npc, out_psr,
           out_opclass, count, overflow_err
  );

endinterface

// File: rtl/decode_in_opclass.sv
// Pre-decode of the head instruction's opcode into a coarse class.
// Output is forced to zero when there is no valid head.
module decode_in_opclass
  import decode_in_buffer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       valid,
  output logic [1:0] opclass
);

  // Classify, zeroing the result when the head is empty.
  always_comb begin
    opclass = 2'd0;
    if (valid) begin
      opclass = classify_opcode(opcode);
    end
  end

endmodule

// File: rtl/decode_in_buffer.sv
// Small FIFO between fetch and decode. Holds {instr, npc, psr} triples,
// presents the head with a pre-decoded opclass, and flags pushes that
// arrive while full. No pass-through: a full queue refuses a push even
// when the head is popped in the same cycle.
module decode_in_buffer
  import decode_in_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int PSR_W  = 3
) (
  input  logic clock,
  input  logic reset,
  decode_in_buffer_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("decode_in_buffer: DEPTH must be a power of two >= 2");
    end
    if (DATA_W < 16) begin : g_bad_width
      $error("decode_in_buffer: DATA_W must be at least 16");
    end
  endgenerate

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [DATA_W-1:0] mem_npc   [DEPTH];
  logic [PSR_W-1:0]  mem_psr   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_instr;
  logic [1:0]        head_opclass;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.enable_decode && !full;
  assign pop   = !empty && bus.out_ready;

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clock) begin
    if (push && !reset && !bus.flush) begin
      mem_instr[wr_ptr] <= bus.instr_dout;
      mem_npc[wr_ptr]   <= bus.npc_in;
      mem_psr[wr_ptr]   <= bus.psr;
    end
  end

  // Pointer, occupancy and sticky overflow tracking; flush beats push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.enable_decode && full) begin
        overflow_q <= 1'b1;
      end
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign head_instr = mem_instr[rd_ptr];

  decode_in_opclass u_opclass (
    .opcode  (head_instr[DATA_W-1 -: 4]),
    .valid   (!empty),
    .opclass (head_opclass)
  );

  // Head presentation; data is zeroed whenever the queue is empty.
  always_comb begin
    bus.out_instr = '0;
    bus.out_npc   = '0;
    bus.out_psr   = '0;
    if (!empty) begin
      bus.out_instr = head_instr;
      bus.out_npc   = mem_npc[rd_ptr];
      bus.out_psr   = mem_psr[rd_ptr];
    end
  end

  assign bus.out_opclass  = head_opclass;
  assign bus.out_valid    = !empty;
  assign bus.in_ready     = !full;
  assign bus.count        = count_q;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_decode_in_buffer.sv
// Directed bench for decode_in_buffer: an opcode/opclass vector table
// plus hand-written sequences for fill, overflow, flush, wrap and reset.
module tb_decode_in_buffer;
  import decode_in_buffer_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int PSR_W  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  decode_in_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PSR_W(PSR_W)) bus ();

  decode_in_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PSR_W(PSR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] npc;
    logic [2:0]  psr;
    logic [1:0]  exp_cls;
  } vec_t;

  vec_t vec [16];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push_one(input logic [15:0] instr, input logic [15:0] npc, input logic [2:0] p);
    bus.enable_decode = 1'b1;
    bus.instr_dout    = instr;
    bus.npc_in        = npc;
    bus.psr           = p;
    step();
    bus.enable_decode = 1'b0;
  endtask

  initial begin
    vec[0]  = '{16'h0E05, 16'h3010, 3'b001, 2'd2};
    vec[1]  = '{16'h1261, 16'h3011, 3'b010, 2'd0};
    vec[2]  = '{16'h2A0F, 16'h3012, 3'b100, 2'd1};
    vec[3]  = '{16'h3E10, 16'h3013, 3'b001, 2'd1};
    vec[4]  = '{16'h4802, 16'h3014, 3'b010, 2'd3};
    vec[5]  = '{16'h5020, 16'h3015, 3'b100, 2'd0};
    vec[6]  = '{16'h6042, 16'h3016, 3'b001, 2'd1};
    vec[7]  = '{16'h7381, 16'h3017, 3'b010, 2'd1};
    vec[8]  = '{16'h8000, 16'h3018, 3'b100, 2'd3};
    vec[9]  = '{16'h967F, 16'h3019, 3'b001, 2'd0};
    vec[10] = '{16'hA203, 16'h301A, 3'b010, 2'd1};
    vec[11] = '{16'hB404, 16'h301B, 3'b100, 2'd1};
    vec[12] = '{16'hC1C0, 16'h301C, 3'b001, 2'd2};
    vec[13] = '{16'hDFFF, 16'h301D, 3'b010, 2'd3};
    vec[14] = '{16'hEA07, 16'h301E, 3'b100, 2'd1};
    vec[15] = '{16'hF025, 16'h301F, 3'b001, 2'd3};

    bus.enable_decode = 1'b0;
    bus.instr_dout    = '0;
    bus.npc_in        = '0;
    bus.psr           = '0;
    bus.flush         = 1'b0;
    bus.out_ready     = 1'b0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
    chk("rst_instr", 32'(bus.out_instr), 32'd0);
    chk("rst_opclass", 32'(bus.out_opclass), 32'd0);

    // First push, one-cycle latency
    push_one(16'h1261, 16'h3001, 3'b010);
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_instr", 32'(bus.out_instr), 32'h1261);
    chk("first_npc", 32'(bus.out_npc), 32'h3001);
    chk("first_psr", 32'(bus.out_psr), 32'd2);
    chk("first_opclass", 32'(bus.out_opclass), 32'd0);
    chk("first_count", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pop_count", 32'(bus.count), 32'd0);
    chk("pop_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_instr_zero", 32'(bus.out_instr), 32'd0);
    chk("empty_npc_zero", 32'(bus.out_npc), 32'd0);

    // Opcode table
    for (int i = 0; i < 16; i++) begin
      push_one(vec[i].instr, vec[i].npc, vec[i].psr);
      chk($sformatf("tbl%0d_instr", i), 32'(bus.out_instr), 32'(vec[i].instr));
      chk($sformatf("tbl%0d_npc", i), 32'(bus.out_npc), 32'(vec[i].npc));
      chk($sformatf("tbl%0d_psr", i), 32'(bus.out_psr), 32'(vec[i].psr));
      chk($sformatf("tbl%0d_opclass", i), 32'(bus.out_opclass), 32'(vec[i].exp_cls));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk($sformatf("tbl%0d_drained", i), 32'(bus.count), 32'd0);
    end

    // Fill to DEPTH, then overflow attempt
    for (int i = 0; i < 4; i++) begin
      push_one(16'h1000 + 16'(i), 16'h4000 + 16'(i), 3'(i));
    end
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_ovf_clear", 32'(bus.overflow_err), 32'd0);
    push_one(16'h6042, 16'h5555, 3'b111);
    chk("ovf_set", 32'(bus.overflow_err), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    chk("ovf_head", 32'(bus.out_instr), 32'h1000);
    step();
    chk("stall_stable_instr", 32'(bus.out_instr), 32'h1000);
    chk("stall_stable_npc", 32'(bus.out_npc), 32'h4000);

    // Full with push and pop in the same cycle
    bus.out_ready = 1'b1;
    push_one(16'h7777, 16'h7777, 3'b000);
    bus.out_ready = 1'b0;
    chk("fullpp_count", 32'(bus.count), 32'd3);
    chk("fullpp_ovf", 32'(bus.overflow_err), 32'd1);
    chk("fullpp_head", 32'(bus.out_instr), 32'h1001);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain%0d_instr", k), 32'(bus.out_instr), 32'h1001 + 32'(k));
      chk($sformatf("drain%0d_npc", k), 32'(bus.out_npc), 32'h4001 + 32'(k));
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_count", 32'(bus.count), 32'd0);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) begin
      push_one(16'h2001 + 16'(i), 16'h0, 3'b0);
    end
    chk("preflush_count", 32'(bus.count), 32'd3);
    bus.flush = 1'b1;
    push_one(16'h0E05, 16'h0E05, 3'b001);
    bus.flush = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("flush_stays_empty", 32'(bus.out_valid), 32'd0);
    push_one(16'h2222, 16'h3333, 3'b100);
    chk("postflush_head", 32'(bus.out_instr), 32'h2222);
    chk("postflush_count", 32'(bus.count), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Streaming through with wrap
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(16'hC000 + 16'(i), 16'h0, 3'b0);
      chk($sformatf("stream%0d_instr", i), 32'(bus.out_instr), 32'hC000 + 32'(i));
      chk($sformatf("stream%0d_opclass", i), 32'(bus.out_opclass), 32'd2);
      chk($sformatf("stream%0d_count", i), 32'(bus.count), 32'd1);
    end
    step();
    bus.out_ready = 1'b0;
    chk("stream_end_count", 32'(bus.count), 32'd0);

    // Reset mid-operation with sticky overflow set
    push_one(16'h1111, 16'h1111, 3'b001);
    push_one(16'h2222, 16'h2222, 3'b010);
    chk("prerst_count", 32'(bus.count), 32'd2);
    chk("prerst_ovf", 32'(bus.overflow_err), 32'd1);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    push_one(16'h3333, 16'h3333, 3'b011);
    reset = 1'b0;
    bus.out_ready = 1'b0;
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow_err), 32'd0);
    chk("midrst_instr", 32'(bus.out_instr), 32'd0);
    chk("midrst_npc", 32'(bus.out_npc), 32'd0);
    chk("midrst_psr", 32'(bus.out_psr), 32'd0);
    chk("midrst_opclass", 32'(bus.out_opclass), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_in_buffer.md
DECODE_IN_BUFFER -- requirements
Module: decode_in_buffer

Interface
REQ-001 Parameter DATA_W, 16, width of instruction and NPC words; minimum 16.
REQ-002 Parameter DEPTH, 4, number of entries; power of two, minimum 2.
REQ-003 Parameter PSR_W, 3, width of PSR (N/Z/P) field.
REQ-004 clock  input  1  single block clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable_decode  input  1  push request from fetch.
REQ-007 instr_dout  input  DATA_W  instruction to enqueue.
REQ-008 npc_in  input  DATA_W  next-PC value paired with the instruction.
REQ-009 psr  input  PSR_W  PSR snapshot paired with the instruction.
REQ-010 flush  input  1  discard all queued entries (branch/redirect).
REQ-011 in_ready  output  1  high when the queue can accept a push.
REQ-012 out_valid  output  1  head entry is valid.
REQ-013 out_ready  input  1  decode consumes the head entry.
REQ-014 out_instr / out_npc / out_psr  output  DATA_W/DATA_W/PSR_W  head entry fields.
REQ-015 out_opclass  output  2  pre-decoded class of the head instruction.
REQ-016 count  output  clog2(DEPTH+1)  current occupancy.
REQ-017 overflow_err  output  1  sticky flag: push attempted while full.

Function
REQ-018 Push occurs when enable_decode and in_ready are both high; the entry {instr_dout, npc_in, psr} is written at the tail.
REQ-019 Pop occurs when out_valid and out_ready are both high; the head advances one entry.
REQ-020 in_ready SHALL equal (count != DEPTH); no pass-through when full, even with a same-cycle pop.
REQ-021 Latency: an entry pushed into an empty queue in cycle N SHALL appear with out_valid high in cycle N+1.
REQ-022 Simultaneous push and pop (not full, not empty): count unchanged; both pointers advance.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; ordering is strictly FIFO.
REQ-024 out_instr/out_npc/out_psr SHALL remain stable while out_valid high and out_ready low.
REQ-025 While out_valid is low, out_instr, out_npc, out_psr and out_opclass SHALL be driven to 0.
REQ-026 out_opclass from head opcode bits [DATA_W-1:DATA_W-4]: ALU=0 (ADD 0001, AND 0101, NOT 1001); MEM=1 (LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011); CTRL=2 (BR 0000, JMP 1100); OTHER=3 (all remaining).
REQ-027 Push while full: data dropped, overflow_err set next cycle and held until reset; queue contents unaffected.
REQ-028 flush high: next cycle count=0, out_valid=0, pointers equal; flush overrides any same-cycle push and pop.
REQ-029 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-030 On reset high at a clock edge: pointers=0, count=0, out_valid=0, in_ready=1, overflow_err=0, data outputs=0.
REQ-031 Reset SHALL override flush, push and pop in the same cycle; mid-operation reset discards all entries.
REQ-032 Storage array contents need not be cleared by reset.

Structure
REQ-033 Shared package decode_in_buffer_pkg SHALL hold the opclass enum (OPC_ALU, OPC_MEM, OPC_CTRL, OPC_OTHER) and the LC3 4-bit opcode constants.
REQ-034 Opcode classification SHALL live in one combinational sub-module, decode_in_opclass.
REQ-035 All parameters SHALL be overridable at instantiation; DEPTH non-power-of-two is a compile-time error.

Verification
REQ-036 Reset, then push instr 16'h1261, npc 16'h3001, psr 3'b010 with out_ready=0 -> next cycle out_valid=1, out_instr=16'h1261, out_opclass=0, count=1.
REQ-037 DEPTH=4: push 4 entries with out_ready=0 -> count=4, in_ready=0; fifth push 16'h6042 -> overflow_err=1, count=4, head unchanged.
REQ-038 Full queue, push and pop in the same cycle -> pop accepted, push rejected, count=3, overflow_err=1.
REQ-039 3 entries queued, flush with concurrent push of 16'h0E05 -> next cycle count=0, out_valid=0, in_ready=1; 16'h0E05 never appears.
REQ-040 Push 10 entries (16'hC000+i) while continuously popping -> output order C000..C009, pointers wrap twice, out_opclass=2 throughout, count returns to 0.
REQ-041 2 entries queued, overflow_err=1, reset asserted -> next cycle count=0, out_valid=0, overflow_err=0, all data outputs 0.
